// File: rtl/rom_port_pkg.sv
// Shared definitions for the ROM port responder: FSM state encoding and default watchdog limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_port_pkg;

   // Access sequencer states: capture in IDLE, strobe in ISSUE, await backend in WAIT, ack in DONE.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } rom_port_state_t;

   // Default watchdog limit, in clk_sys cycles spent waiting for the backend.
   localparam int ROM_PORT_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rom_port_responder.sv
// Toggle-handshake port responder: turns one req/ack toggle into one backend access (read or byte-masked write).
// Latency: req toggle to ack toggle = 3 cycles + backend latency (4 with mem_rdy one cycle after mem_cs).
// Backpressure: one access in flight; port_* is sampled only in the IDLE capture cycle, a toggle while busy is not queued.
//
// Ports:
//   clk_sys, reset          sole clock; synchronous active-high reset
//   port_req / port_ack     request/acknowledge toggles; pending while they differ
//   port_a/ds/we/d, port_q  initiator address, byte strobes, direction, write data, read data
//   mem_cs/we/addr/be/wdata one-cycle backend strobe with the captured access fields
//   mem_rdata, mem_rdy      backend read data and one-cycle completion pulse
//   busy, err               access in progress; sticky watchdog flag
//
// Build option: define ROM_PORT_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT cycles), otherwise err is 0.
module rom_port_responder
   import rom_port_pkg::*;
#(
   parameter int AW      = 23,
   parameter int DW      = 16,
   parameter int TIMEOUT = ROM_PORT_TIMEOUT_DEFAULT
) (
   input  logic            clk_sys,
   input  logic            reset,
   input  logic            port_req,
   output logic            port_ack,
   input  logic [AW-1:0]   port_a,
   input  logic [DW/8-1:0] port_ds,
   input  logic            port_we,
   input  logic [DW-1:0]   port_d,
   output logic [DW-1:0]   port_q,
   output logic            mem_cs,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW/8-1:0] mem_be,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_rdy,
   output logic            busy,
   output logic            err
);

   if ((DW % 8) != 0 || TIMEOUT < 1) begin : g_bad_params
      $error("rom_port_responder: DW must be a multiple of 8 and TIMEOUT at least 1");
   end

   rom_port_state_t state_q, state_d;
   logic            req_pending;
   logic            timeout_hit;

   assign req_pending = (port_req != port_ack);
   assign busy        = (state_q != IDLE);

`ifdef ROM_PORT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wd_cnt;
   logic          err_q;

   // Counts completed WAIT cycles; the TIMEOUT-th one without mem_rdy abandons the access.
   assign timeout_hit = (state_q == WAIT) && (wd_cnt == CW'(TIMEOUT - 1));
   assign err         = err_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else if (state_q == WAIT && !mem_rdy) begin
         if (timeout_hit) begin
            wd_cnt <= '0;
            err_q  <= 1'b1;
         end else begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end else begin
         wd_cnt <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_pending) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         // mem_rdy wins over a watchdog expiry landing in the same cycle.
         WAIT:    if (mem_rdy || timeout_hit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The mem_* registers double as the capture registers, so they hold the
   // access fields for the whole access; mem_cs alone marks the issue cycle.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         port_ack  <= 1'b0;
         port_q    <= '0;
         mem_cs    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
      end else begin
         mem_cs <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_pending) begin
                  mem_cs    <= 1'b1;
                  mem_we    <= port_we;
                  mem_addr  <= port_a;
                  mem_be    <= port_ds;
                  mem_wdata <= port_d;
               end
            end
            WAIT: begin
               // Reads take the full backend word; strobes never mask read data.
               if (mem_rdy && !mem_we) port_q <= mem_rdata;
            end
            DONE: begin
               port_ack <= ~port_ack;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_port_responder.sv
module tb_rom_port_responder;

   localparam int AW  = 23;
   localparam int DW  = 16;
   localparam int TMO = 16;

   typedef struct packed {
      logic            we;
      logic [AW-1:0]   addr;
      logic [DW/8-1:0] be;
      logic [DW-1:0]   wdata;
   } mem_exp_t;

   logic            clk_sys = 1'b0;
   logic            reset;
   logic            port_req;
   logic            port_ack;
   logic [AW-1:0]   port_a;
   logic [DW/8-1:0] port_ds;
   logic            port_we;
   logic [DW-1:0]   port_d;
   logic [DW-1:0]   port_q;
   logic            mem_cs;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW/8-1:0] mem_be;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;
   logic            mem_rdy;
   logic            busy;
   logic            err;

   mem_exp_t        mem_q[$];
   logic [DW-1:0]   ack_q[$];
   int              checks = 0;
   int              errors = 0;
   int              cur_delay = 1;
   int              cs_pulses = 0;
   int              acks_seen = 0;
   int              issued = 0;
   int              acks_expected = 0;
   logic [DW-1:0]   model_q = '0;

   rom_port_responder #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .port_req (port_req),
      .port_ack (port_ack),
      .port_a   (port_a),
      .port_ds  (port_ds),
      .port_we  (port_we),
      .port_d   (port_d),
      .port_q   (port_q),
      .mem_cs   (mem_cs),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_be   (mem_be),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_rdy  (mem_rdy),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk_sys = ~clk_sys;

   // Backend ROM contents as seen by the bench.
   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      if (a == 23'h000123) return 16'hBEEF;
      return a[15:0] ^ {a[22:16], a[8:0]} ^ 16'h5A3C;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Backend model: completes each strobe cur_delay cycles later (0 = never).
   initial begin
      int              bk_cnt;
      logic [AW-1:0]   bk_addr;
      bk_cnt    = 0;
      bk_addr   = '0;
      mem_rdy   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk_sys);
         #2;
         mem_rdy = 1'b0;
         if (reset) begin
            bk_cnt = 0;
         end else begin
            if (bk_cnt > 0) begin
               bk_cnt--;
               if (bk_cnt == 0) begin
                  mem_rdy   = 1'b1;
                  mem_rdata = rom_word(bk_addr);
               end
            end
            if (mem_cs === 1'b1) begin
               bk_cnt  = cur_delay;
               bk_addr = mem_addr;
            end
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      logic          prev_cs;
      logic          last_ack;
      mem_exp_t      e;
      logic [DW-1:0] q;
      prev_cs  = 1'b0;
      last_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (reset) begin
            prev_cs  = 1'b0;
            last_ack = port_ack;
         end else begin
            if (mem_cs === 1'b1) begin
               cs_pulses++;
               chk("mem_cs_single_cycle", 32'(prev_cs), 32'(0));
               if (mem_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_mem_cs: addr %h with no access outstanding", mem_addr);
               end else begin
                  e = mem_q.pop_front();
                  chk("mem_we",    32'(mem_we),    32'(e.we));
                  chk("mem_addr",  32'(mem_addr),  32'(e.addr));
                  chk("mem_be",    32'(mem_be),    32'(e.be));
                  chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
               end
            end
            prev_cs = (mem_cs === 1'b1);
            if (port_ack !== last_ack) begin
               last_ack = port_ack;
               acks_seen++;
               if (ack_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ack: port_ack %b with no access outstanding", port_ack);
               end else begin
                  q = ack_q.pop_front();
                  chk("port_q_at_ack", 32'(port_q), 32'(q));
               end
            end
         end
      end
   end

   // Issue one access and wait for its ack; dbl=1 adds two extra req toggles while busy.
   task automatic do_access(input logic we, input logic [AW-1:0] a, input logic [DW/8-1:0] ds,
                            input logic [DW-1:0] d, input int delay, input bit dbl);
      logic old_ack;
      int   n;
      int   exp_lat;
      mem_exp_t e;
      port_we   = we;
      port_a    = a;
      port_ds   = ds;
      port_d    = d;
      cur_delay = delay;
      e.we = we; e.addr = a; e.be = ds; e.wdata = d;
      mem_q.push_back(e);
      issued++;
      if (!we && delay > 0) model_q = rom_word(a);
      ack_q.push_back(model_q);
      acks_expected++;
      exp_lat = (delay > 0) ? 3 + delay : 3 + TMO;
      old_ack  = port_ack;
      port_req = ~port_req;
      n = 0;
      while (port_ack === old_ack && n < 200) begin
         @(posedge clk_sys);
         #1;
         n++;
         if (n == 1) chk("busy_during_access", 32'(busy), 32'(1));
         if (dbl && (n == 1 || n == 2)) port_req = ~port_req;
      end
      if (port_ack === old_ack) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: no ack toggle after %0d cycles", n);
      end else begin
         chk("ack_latency", 32'(n), 32'(exp_lat));
         chk("busy_after_ack", 32'(busy), 32'(0));
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [AW-1:0] ra;
      int n;
      mem_exp_t e;

      reset    = 1'b1;
      port_req = 1'b0;
      port_a   = '0;
      port_ds  = '0;
      port_we  = 1'b0;
      port_d   = '0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_port_ack",  32'(port_ack),  32'(0));
      chk("rst_port_q",    32'(port_q),    32'(0));
      chk("rst_mem_cs",    32'(mem_cs),    32'(0));
      chk("rst_mem_we",    32'(mem_we),    32'(0));
      chk("rst_mem_addr",  32'(mem_addr),  32'(0));
      chk("rst_mem_be",    32'(mem_be),    32'(0));
      chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      chk("rst_busy",      32'(busy),      32'(0));
      chk("rst_err",       32'(err),       32'(0));
      reset = 1'b0;

      // Reset while waiting on a slow backend, with port_req held high.
      port_we = 1'b0; port_a = 23'h000456; port_ds = 2'b11; port_d = '0; cur_delay = 10;
      e.we = 1'b0; e.addr = 23'h000456; e.be = 2'b11; e.wdata = '0;
      mem_q.push_back(e);
      issued++;
      port_req = 1'b1;
      repeat (2) begin @(posedge clk_sys); #1; end
      chk("busy_before_reset", 32'(busy), 32'(1));
      reset = 1'b1;
      @(posedge clk_sys);
      #1;
      reset = 1'b0;
      chk("reset_wait_ack",  32'(port_ack), 32'(0));
      chk("reset_wait_busy", 32'(busy),     32'(0));
      chk("reset_wait_q",    32'(port_q),   32'(0));
      cur_delay = 1;
      mem_q.push_back(e);
      issued++;
      model_q = rom_word(23'h000456);
      ack_q.push_back(model_q);
      acks_expected++;
      n = 0;
      while (port_ack !== 1'b1 && n < 200) begin @(posedge clk_sys); #1; n++; end
      chk("reservice_latency", 32'(n), 32'(4));

      // Directed read and write.
      do_access(1'b0, 23'h000123, 2'b11, 16'h0000, 1, 1'b0);
      chk("read_port_q", 32'(port_q), 32'hBEEF);
      do_access(1'b1, 23'h000200, 2'b10, 16'hA5A5, 1, 1'b0);
      chk("write_port_q_held", 32'(port_q), 32'hBEEF);

      // Eight back-to-back writes, each issued on the previous ack.
      for (int i = 0; i < 8; i++)
         do_access(1'b1, 23'h001000 + 23'(i), 2'b11, 16'(16'h1100 + i), 1, 1'b0);

      // Two extra toggles while busy cancel out.
      do_access(1'b0, 23'h000777, 2'b01, 16'h0000, 2, 1'b1);
      repeat (15) @(posedge clk_sys);
      #1;
      chk("dbl_no_pending", 32'(port_ack == port_req), 32'(1));
      chk("dbl_idle_busy",  32'(busy), 32'(0));

`ifdef ROM_PORT_TIMEOUT_EN
      do_access(1'b0, 23'h000321, 2'b11, 16'h0000, 0, 1'b0);
      chk("timeout_err", 32'(err), 32'(1));
      do_access(1'b0, 23'h000322, 2'b11, 16'h0000, 1, 1'b0);
      chk("err_sticky", 32'(err), 32'(1));
`else
      chk("err_tied_low", 32'(err), 32'(0));
`endif

      // Randomized accesses against the model.
      for (int i = 0; i < 40; i++) begin
         r  = $urandom;
         ra = r[AW-1:0];
         r  = $urandom;
         do_access(1'(r[31]), ra, r[17:16], r[15:0], $urandom_range(1, 4), 1'b0);
      end

      repeat (10) @(posedge clk_sys);
      #1;
      chk("mem_q_drained",  32'(mem_q.size()), 32'(0));
      chk("ack_q_drained",  32'(ack_q.size()), 32'(0));
      chk("mem_cs_pulses",  32'(cs_pulses),    32'(issued));
      chk("ack_toggles",    32'(acks_seen),    32'(acks_expected));
`ifndef ROM_PORT_TIMEOUT_EN
      chk("err_final", 32'(err), 32'(0));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
